// File: rtl/alu_operand_loader_if.sv
// Bus bundle between the operand loader and its environment (switches, buttons, ALU, display).
// The loader takes the slave view; whatever drives the switches and the ALU takes the master view.
interface alu_operand_loader_if #(
  parameter int N     = 16,
  parameter int CNT_W = 8
);
  logic [N-1:0]     data_in;
  logic             enter;
  logic             undo;
  logic [N-1:0]     alu_result;
  logic             alu_status;
  logic [N-1:0]     OP1;
  logic [N-1:0]     OP2;
  logic [1:0]       OpCode;
  logic [1:0]       stage;
  logic             valid;
  logic [N-1:0]     result_latched;
  logic             status_latched;
  logic [N-1:0]     display_value;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  data_in, enter, undo, alu_result, alu_status,
    output OP1, OP2, OpCode, stage, valid, result_latched, status_latched,
           display_value, ops_done
  );

  modport master (
    output data_in, enter, undo, alu_result, alu_status,
    input  OP1, OP2, OpCode, stage, valid, result_latched, status_latched,
           display_value, ops_done
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Operand-entry stage for the 4-op ALU: steps through OP1/OP2/opcode on enter edges,
// then captures the ALU result two clocks after the opcode is entered.
module alu_operand_loader #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_OP1 = 2'b00,
    S_OP2 = 2'b01,
    S_OPC = 2'b10,
    S_RES = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     op1_q, op1_d;
  logic [N-1:0]     op2_q, op2_d;
  logic [1:0]       opc_q, opc_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     res_q, res_d;
  logic             stat_q, stat_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             cap_q, cap_d;
  logic             enter_q, undo_q;
  logic             enter_rise_s, undo_rise_s;

  assign enter_rise_s = bus.enter & ~enter_q;
  assign undo_rise_s  = bus.undo  & ~undo_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_OP1;
      op1_q   <= {N{1'b0}};
      op2_q   <= {N{1'b0}};
      opc_q   <= 2'b00;
      valid_q <= 1'b0;
      res_q   <= {N{1'b0}};
      stat_q  <= 1'b0;
      ops_q   <= {CNT_W{1'b0}};
      cap_q   <= 1'b0;
      enter_q <= 1'b0;
      undo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      stat_q  <= stat_d;
      ops_q   <= ops_d;
      cap_q   <= cap_d;
      enter_q <= bus.enter;
      undo_q  <= bus.undo;
    end
  end

  // Next-state logic; undo outranks enter, and any button edge cancels a pending capture.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    res_d   = res_q;
    stat_d  = stat_q;
    ops_d   = ops_q;
    cap_d   = cap_q;
    if (undo_rise_s) begin
      case (state_q)
        S_OP1: state_d = S_OP1;
        S_OP2: state_d = S_OP1;
        S_OPC: state_d = S_OP2;
        S_RES: begin
          state_d = S_OPC;
          valid_d = 1'b0;
          cap_d   = 1'b0;
        end
        default: state_d = S_OP1;
      endcase
    end else if (enter_rise_s) begin
      case (state_q)
        S_OP1: begin
          op1_d   = bus.data_in;
          state_d = S_OP2;
        end
        S_OP2: begin
          op2_d   = bus.data_in;
          state_d = S_OPC;
        end
        S_OPC: begin
          opc_d   = bus.data_in[1:0];
          state_d = S_RES;
          cap_d   = 1'b1;
        end
        S_RES: begin
          state_d = S_OP1;
          valid_d = 1'b0;
          cap_d   = 1'b0;
        end
        default: state_d = S_OP1;
      endcase
    end else if ((state_q == S_RES) && cap_q) begin
      // OpCode has been on the ALU for a full cycle, so its result is settled here.
      res_d   = bus.alu_result;
      stat_d  = bus.alu_status;
      valid_d = 1'b1;
      cap_d   = 1'b0;
      ops_d   = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      state_d = state_q;
    end
  end

  // Display source selection.
  always_comb begin
    bus.display_value = bus.data_in;
    case (state_q)
      S_OPC:   bus.display_value = {{(N-2){1'b0}}, bus.data_in[1:0]};
      S_RES:   bus.display_value = valid_q ? res_q : bus.data_in;
      default: bus.display_value = bus.data_in;
    endcase
  end

  assign bus.OP1            = op1_q;
  assign bus.OP2            = op2_q;
  assign bus.OpCode         = opc_q;
  assign bus.stage          = state_q;
  assign bus.valid          = valid_q;
  assign bus.result_latched = res_q;
  assign bus.status_latched = stat_q;
  assign bus.ops_done       = ops_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a behavioural add/sub/and/or ALU on its outputs.
module tb_alu_operand_loader;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   exp_ops;

  alu_operand_loader_if #(.N(16), .CNT_W(8)) bus ();

  alu_operand_loader #(.N(16), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] sum17;
  assign sum17 = {1'b0, bus.OP1} + {1'b0, bus.OP2};
  always_comb begin
    bus.alu_status = 1'b0;
    case (bus.OpCode)
      2'b00: begin
        bus.alu_result = sum17[15:0];
        bus.alu_status = sum17[16];
      end
      2'b01:   bus.alu_result = bus.OP1 - bus.OP2;
      2'b10:   bus.alu_result = bus.OP1 & bus.OP2;
      default: bus.alu_result = bus.OP1 | bus.OP2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [15:0] d);
    bus.data_in = d;
    bus.enter   = 1'b1;
    step();
    bus.enter   = 1'b0;
    step();
  endtask

  task automatic press_undo();
    bus.undo = 1'b1;
    step();
    bus.undo = 1'b0;
    step();
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] opc);
    press(a);
    press(b);
    press(opc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    bus.data_in = 16'h0000;
    bus.enter   = 1'b0;
    bus.undo    = 1'b0;
    reset       = 1'b1;
    do_reset();

    // 1: reset state and 3 + 4
    chk("rst_stage", 32'(bus.stage), 32'h0);
    chk("rst_op1", 32'(bus.OP1), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_ops", 32'(bus.ops_done), 32'h0);
    chk("rst_res", 32'(bus.result_latched), 32'h0);
    press(16'h0003);
    press(16'h0004);
    chk("t1_op1", 32'(bus.OP1), 32'h3);
    chk("t1_op2", 32'(bus.OP2), 32'h4);
    chk("t1_stage_opc", 32'(bus.stage), 32'h2);
    bus.data_in = 16'h0000;
    bus.enter   = 1'b1;
    step();
    chk("t1_stage_res", 32'(bus.stage), 32'h3);
    chk("t1_valid_k1", 32'(bus.valid), 32'h0);
    bus.enter = 1'b0;
    step();
    chk("t1_valid_k2", 32'(bus.valid), 32'h1);
    chk("t1_result", 32'(bus.result_latched), 32'h7);
    chk("t1_status", 32'(bus.status_latched), 32'h0);
    chk("t1_ops", 32'(bus.ops_done), 32'h1);
    chk("t1_disp", 32'(bus.display_value), 32'h7);

    // 2: add overflow, then OR with display of unlatched S_RES
    do_reset();
    do_op(16'hFFFF, 16'h0001, 16'h0000);
    chk("t2_res_ovf", 32'(bus.result_latched), 32'h0);
    chk("t2_stat_ovf", 32'(bus.status_latched), 32'h1);
    press(16'h0000);
    chk("t2_back_op1", 32'(bus.stage), 32'h0);
    chk("t2_valid_clr", 32'(bus.valid), 32'h0);
    press(16'h00F0);
    press(16'h0F0F);
    bus.data_in = 16'hABC3;
    bus.enter   = 1'b1;
    step();
    chk("t2_disp_nov", 32'(bus.display_value), 32'hABC3);
    chk("t2_opcode", 32'(bus.OpCode), 32'h3);
    bus.enter = 1'b0;
    step();
    chk("t2_res_or", 32'(bus.result_latched), 32'h0FFF);
    chk("t2_stat_or", 32'(bus.status_latched), 32'h0);
    chk("t2_ops", 32'(bus.ops_done), 32'h2);

    // 3: held enter gives a single edge
    press(16'h0000);
    bus.data_in = 16'h1234;
    bus.enter   = 1'b1;
    for (int i = 0; i < 50; i++) step();
    chk("t3_held_stage", 32'(bus.stage), 32'h1);
    chk("t3_held_op1", 32'(bus.OP1), 32'h1234);
    bus.enter = 1'b0;
    step();
    press(16'h0055);
    chk("t3_stage_opc", 32'(bus.stage), 32'h2);
    chk("t3_op2", 32'(bus.OP2), 32'h0055);

    // 4: undo paths
    press_undo();
    chk("t4_undo_opc", 32'(bus.stage), 32'h1);
    bus.data_in = 16'h9999;
    bus.enter   = 1'b1;
    bus.undo    = 1'b1;
    step();
    bus.enter = 1'b0;
    bus.undo  = 1'b0;
    step();
    chk("t4_both_stage", 32'(bus.stage), 32'h0);
    chk("t4_both_op2", 32'(bus.OP2), 32'h0055);
    do_op(16'h0001, 16'h0002, 16'h0001);
    chk("t4_sub_res", 32'(bus.result_latched), 32'hFFFF);
    chk("t4_sub_valid", 32'(bus.valid), 32'h1);
    exp_ops = 3;
    chk("t4_ops", 32'(bus.ops_done), 32'(exp_ops));
    bus.data_in = 16'h0006;
    press_undo();
    chk("t4_undo_res", 32'(bus.stage), 32'h2);
    chk("t4_undo_valid", 32'(bus.valid), 32'h0);
    chk("t4_disp_opc", 32'(bus.display_value), 32'h0002);

    // 5: aborted capture, then reset mid-entry
    bus.data_in = 16'h0000;
    bus.enter   = 1'b1;
    step();
    bus.enter = 1'b0;
    bus.undo  = 1'b1;
    step();
    bus.undo = 1'b0;
    step();
    chk("t5_abort_valid", 32'(bus.valid), 32'h0);
    chk("t5_abort_ops", 32'(bus.ops_done), 32'(exp_ops));
    chk("t5_abort_stage", 32'(bus.stage), 32'h2);
    bus.data_in = 16'h00A5;
    reset       = 1'b1;
    #1;
    chk("t5_rst_stage", 32'(bus.stage), 32'h0);
    chk("t5_rst_op1", 32'(bus.OP1), 32'h0);
    chk("t5_rst_op2", 32'(bus.OP2), 32'h0);
    chk("t5_rst_opc", 32'(bus.OpCode), 32'h0);
    chk("t5_rst_res", 32'(bus.result_latched), 32'h0);
    chk("t5_rst_ops", 32'(bus.ops_done), 32'h0);
    chk("t5_rst_disp", 32'(bus.display_value), 32'h00A5);
    step();
    reset = 1'b0;
    step();

    // 6: counter wrap
    for (int i = 0; i < 255; i++) begin
      do_op(16'(i), 16'h0001, 16'h0000);
      press(16'h0000);
    end
    chk("t6_ops_255", 32'(bus.ops_done), 32'hFF);
    do_op(16'h0010, 16'h0020, 16'h0000);
    chk("t6_ops_wrap", 32'(bus.ops_done), 32'h0);
    chk("t6_wrap_res", 32'(bus.result_latched), 32'h0030);
    chk("t6_disp_valid", 32'(bus.display_value), 32'h0030);
    press(16'h7777);
    chk("t6_disp_inv", 32'(bus.display_value), 32'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
